// File: rtl/scrisc_ctrl_fsm.sv
// Moore control FSM for a small 16-bit RISC core: fetch/decode/execute sequencing,
// memory handshakes with an ack timeout, and sticky status flags.
module scrisc_ctrl_fsm #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        imem_ack,
    input  logic        mem_ack,
    input  logic        check,
    output logic        imem_req,
    output logic [15:0] ir,
    output logic        ir_load,
    output logic        pc_inc,
    output logic        pc_load,
    output logic [3:0]  alu_c,
    output logic [2:0]  alu_b,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        rf_we,
    output logic        halted,
    output logic        illegal,
    output logic        bus_err
);

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    // A wait cycle that ends with the counter at ACK_TIMEOUT and no ack is fatal.
    localparam logic [7:0] LAST_WAIT = 8'(ACK_TIMEOUT - 1);

    state_t      state, state_nx;
    logic [7:0]  cnt, cnt_nx;
    logic [15:0] ir_nx;
    logic [3:0]  alu_c_nx;
    logic [2:0]  alu_b_nx;
    logic        imem_req_nx, ir_load_nx, pc_inc_nx, pc_load_nx;
    logic        mem_rd_nx, mem_wr_nx, rf_we_nx;
    logic        halted_nx, illegal_nx, bus_err_nx;
    logic [3:0]  op;

    assign op = ir[15:12];

    function automatic logic [3:0] alu_code(input logic [3:0] opc);
        case (opc)
            4'h1:    alu_code = 4'b1100;
            4'h2:    alu_code = 4'b1101;
            4'h3:    alu_code = 4'b1000;
            4'h4:    alu_code = 4'b1001;
            4'h5:    alu_code = 4'b1010;
            4'h6:    alu_code = 4'b1011;
            4'h7:    alu_code = 4'b0100;
            4'h8:    alu_code = 4'b0110;
            4'h9:    alu_code = 4'b0111;
            4'hA:    alu_code = 4'b1100;
            4'hB:    alu_code = 4'b1100;
            4'hC:    alu_code = 4'b1101;
            default: alu_code = 4'b0000;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            ir       <= '0;
            alu_c    <= '0;
            alu_b    <= '0;
            imem_req <= 1'b0;
            ir_load  <= 1'b0;
            pc_inc   <= 1'b0;
            pc_load  <= 1'b0;
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
            rf_we    <= 1'b0;
            halted   <= 1'b0;
            illegal  <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            ir       <= ir_nx;
            alu_c    <= alu_c_nx;
            alu_b    <= alu_b_nx;
            imem_req <= imem_req_nx;
            ir_load  <= ir_load_nx;
            pc_inc   <= pc_inc_nx;
            pc_load  <= pc_load_nx;
            mem_rd   <= mem_rd_nx;
            mem_wr   <= mem_wr_nx;
            rf_we    <= rf_we_nx;
            halted   <= halted_nx;
            illegal  <= illegal_nx;
            bus_err  <= bus_err_nx;
        end
    end

    // Outputs are computed for the state being entered, so every strobe is a register.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        ir_nx       = ir;
        alu_c_nx    = alu_c;
        alu_b_nx    = alu_b;
        imem_req_nx = 1'b0;
        ir_load_nx  = 1'b0;
        pc_inc_nx   = 1'b0;
        pc_load_nx  = 1'b0;
        mem_rd_nx   = 1'b0;
        mem_wr_nx   = 1'b0;
        rf_we_nx    = 1'b0;
        halted_nx   = halted;
        illegal_nx  = illegal;
        bus_err_nx  = bus_err;
        case (state)
            IDLE: begin
                state_nx    = FETCH;
                cnt_nx      = '0;
                imem_req_nx = 1'b1;
            end
            FETCH: begin
                if (imem_ack) begin
                    state_nx   = DECODE;
                    ir_nx      = instr;
                    ir_load_nx = 1'b1;
                    pc_inc_nx  = 1'b1;
                    alu_c_nx   = alu_code(instr[15:12]);
                    alu_b_nx   = (instr[15:12] == 4'hC) ? instr[11:9] : 3'b000;
                end else if (cnt == LAST_WAIT) begin
                    state_nx   = HALT;
                    cnt_nx     = cnt + 8'd1;
                    bus_err_nx = 1'b1;
                    halted_nx  = 1'b1;
                end else begin
                    cnt_nx      = cnt + 8'd1;
                    imem_req_nx = 1'b1;
                end
            end
            DECODE: begin
                case (op)
                    4'h0: begin
                        state_nx    = FETCH;
                        cnt_nx      = '0;
                        imem_req_nx = 1'b1;
                    end
                    4'hE: begin
                        state_nx    = FETCH;
                        cnt_nx      = '0;
                        imem_req_nx = 1'b1;
                        illegal_nx  = 1'b1;
                    end
                    4'hF: begin
                        state_nx  = HALT;
                        halted_nx = 1'b1;
                    end
                    4'hC: begin
                        state_nx   = EXEC;
                        pc_load_nx = check;
                    end
                    4'hD: begin
                        state_nx   = EXEC;
                        pc_load_nx = 1'b1;
                    end
                    default: state_nx = EXEC;
                endcase
            end
            EXEC: begin
                case (op)
                    4'hA: begin
                        state_nx  = MEM;
                        cnt_nx    = '0;
                        mem_rd_nx = 1'b1;
                    end
                    4'hB: begin
                        state_nx  = MEM;
                        cnt_nx    = '0;
                        mem_wr_nx = 1'b1;
                    end
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
                        state_nx = WB;
                        rf_we_nx = 1'b1;
                    end
                    default: begin
                        state_nx    = FETCH;
                        cnt_nx      = '0;
                        imem_req_nx = 1'b1;
                    end
                endcase
            end
            MEM: begin
                if (mem_ack) begin
                    if (op == 4'hA) begin
                        state_nx = WB;
                        rf_we_nx = 1'b1;
                    end else begin
                        state_nx    = FETCH;
                        cnt_nx      = '0;
                        imem_req_nx = 1'b1;
                    end
                end else if (cnt == LAST_WAIT) begin
                    state_nx   = HALT;
                    cnt_nx     = cnt + 8'd1;
                    bus_err_nx = 1'b1;
                    halted_nx  = 1'b1;
                end else begin
                    cnt_nx    = cnt + 8'd1;
                    mem_rd_nx = mem_rd;
                    mem_wr_nx = mem_wr;
                end
            end
            WB: begin
                state_nx    = FETCH;
                cnt_nx      = '0;
                imem_req_nx = 1'b1;
            end
            HALT:    state_nx = HALT;
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_scrisc_ctrl_fsm.sv
// Bench for scrisc_ctrl_fsm: instructions are expanded into expected per-cycle output
// traces from the instruction-level rules, then replayed against the DUT.
module tb_scrisc_ctrl_fsm;

    localparam int T = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instr = '0;
    logic        imem_ack = 1'b0, mem_ack = 1'b0, check = 1'b0;
    logic        imem_req, ir_load, pc_inc, pc_load, mem_rd, mem_wr, rf_we;
    logic        halted, illegal, bus_err;
    logic [15:0] ir;
    logic [3:0]  alu_c;
    logic [2:0]  alu_b;

    int n_cmp = 0;
    int n_err = 0;

    scrisc_ctrl_fsm #(.ACK_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .instr(instr), .imem_ack(imem_ack), .mem_ack(mem_ack),
        .check(check), .imem_req(imem_req), .ir(ir), .ir_load(ir_load), .pc_inc(pc_inc),
        .pc_load(pc_load), .alu_c(alu_c), .alu_b(alu_b), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .rf_we(rf_we), .halted(halted), .illegal(illegal), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    logic [32:0] obs;
    assign obs = {imem_req, ir, ir_load, pc_inc, pc_load, alu_c, alu_b,
                  mem_rd, mem_wr, rf_we, halted, illegal, bus_err};

    typedef struct {
        logic        ia, ma, ck;
        logic [15:0] ins;
        logic [32:0] exp;
    } cyc_t;

    cyc_t trace[$];

    // Architectural view the bench expects to see
    logic [15:0] e_ir;
    logic [3:0]  e_alu_c;
    logic [2:0]  e_alu_b;
    logic        e_ill, e_halt, e_berr;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [15:0] rw();
        return 16'($urandom);
    endfunction

    function automatic logic [3:0] op_alu(input logic [3:0] op);
        case (op)
            4'h1, 4'hA, 4'hB: return 4'b1100;
            4'h2, 4'hC:       return 4'b1101;
            4'h3:             return 4'b1000;
            4'h4:             return 4'b1001;
            4'h5:             return 4'b1010;
            4'h6:             return 4'b1011;
            4'h7:             return 4'b0100;
            4'h8:             return 4'b0110;
            4'h9:             return 4'b0111;
            default:          return 4'b0000;
        endcase
    endfunction

    task automatic add(input logic ia, input logic ma, input logic ck, input logic [15:0] ins,
                       input logic req, input logic il, input logic pi, input logic pl,
                       input logic rd, input logic wr, input logic we);
        cyc_t c;
        c.ia  = ia;
        c.ma  = ma;
        c.ck  = ck;
        c.ins = ins;
        c.exp = {req, e_ir, il, pi, pl, e_alu_c, e_alu_b, rd, wr, we, e_halt, e_ill, e_berr};
        trace.push_back(c);
    endtask

    task automatic add_halt_cycles();
        for (int k = 0; k < 6; k++)
            add(rb(), rb(), rb(), rw(), 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_fetch(input int w, input logic [15:0] ins, output bit to);
        to = 0;
        for (int k = 0; k < w && k < T; k++)
            add(1'b0, rb(), rb(), rw(), 1, 0, 0, 0, 0, 0, 0);
        if (w >= T) begin
            e_berr = 1'b1;
            e_halt = 1'b1;
            to = 1;
        end else begin
            add(1'b1, rb(), rb(), ins, 1, 0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic do_mem(input logic rd, input logic wr, input int w, output bit to);
        to = 0;
        for (int k = 0; k < w && k < T; k++)
            add(rb(), 1'b0, rb(), rw(), 0, 0, 0, 0, rd, wr, 0);
        if (w >= T) begin
            e_berr = 1'b1;
            e_halt = 1'b1;
            to = 1;
        end else begin
            add(rb(), 1'b1, rb(), rw(), 0, 0, 0, 0, rd, wr, 0);
        end
    endtask

    // Expand one instruction (fetch wait wf, memory wait wm, branch condition ck) into cycles.
    task automatic run_instr(input logic [15:0] ins, input int wf, input int wm, input logic ck);
        bit to;
        logic [3:0] op;
        if (e_halt) return;
        op = ins[15:12];
        do_fetch(wf, ins, to);
        if (to) begin
            add_halt_cycles();
            return;
        end
        e_ir    = ins;
        e_alu_c = op_alu(op);
        e_alu_b = (op == 4'hC) ? ins[11:9] : 3'b000;
        add(rb(), rb(), ck, rw(), 0, 1, 1, 0, 0, 0, 0);
        case (op)
            4'h0: ;
            4'hE: e_ill = 1'b1;
            4'hF: begin
                e_halt = 1'b1;
                add_halt_cycles();
            end
            4'hA, 4'hB: begin
                add(rb(), rb(), rb(), rw(), 0, 0, 0, 0, 0, 0, 0);
                do_mem(op == 4'hA, op == 4'hB, wm, to);
                if (to) add_halt_cycles();
                else if (op == 4'hA) add(rb(), rb(), rb(), rw(), 0, 0, 0, 0, 0, 0, 1);
            end
            4'hC: add(rb(), rb(), rb(), rw(), 0, 0, 0, ck, 0, 0, 0);
            4'hD: add(rb(), rb(), rb(), rw(), 0, 0, 0, 1, 0, 0, 0);
            default: begin
                add(rb(), rb(), rb(), rw(), 0, 0, 0, 0, 0, 0, 0);
                add(rb(), rb(), rb(), rw(), 0, 0, 0, 0, 0, 0, 1);
            end
        endcase
    endtask

    task automatic play(input int limit);
        cyc_t c;
        int n = 0;
        while (trace.size() > 0 && n < limit) begin
            c = trace.pop_front();
            @(negedge clk);
            check_eq("cycle", 64'(obs), 64'(c.exp));
            imem_ack = c.ia;
            mem_ack  = c.ma;
            check    = c.ck;
            instr    = c.ins;
            n++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_eq("rst_async", 64'(obs), 64'd0);
        trace.delete();
        e_ir = '0; e_alu_c = '0; e_alu_b = '0;
        e_ill = 1'b0; e_halt = 1'b0; e_berr = 1'b0;
        repeat (2) begin
            @(negedge clk);
            imem_ack = rb(); mem_ack = rb(); check = rb(); instr = rw();
        end
        check_eq("rst_hold", 64'(obs), 64'd0);
        rst = 1'b0;
    endtask

    initial begin
        int r;
        logic [3:0] op;
        int wf, wm;

        // ADD then a following fetch
        do_reset();
        run_instr(16'h1234, 0, 0, 1'b0);
        run_instr(16'h0000, 2, 0, 1'b0);
        play(1000);

        // Taken / not-taken branch, jump
        do_reset();
        run_instr(16'hC600, 1, 0, 1'b1);
        run_instr(16'hC600, 0, 0, 1'b0);
        run_instr(16'hD000, 0, 0, 1'b0);
        run_instr(16'h0000, 0, 0, 1'b0);
        play(1000);

        // Load with delayed ack, store
        do_reset();
        run_instr(16'hA123, 0, 4, 1'b0);
        run_instr(16'hB000, 1, 2, 1'b0);
        run_instr(16'h0000, 0, 0, 1'b0);
        play(1000);

        // Fetch timeout
        do_reset();
        run_instr(16'h1111, T, 0, 1'b0);
        play(1000);

        // Acks on the last allowed cycle, then a memory timeout
        do_reset();
        run_instr(16'h2222, T - 1, 0, 1'b0);
        run_instr(16'hA000, 0, T - 1, 1'b0);
        run_instr(16'hB000, 0, T, 1'b0);
        play(1000);

        // Illegal opcode then halt
        do_reset();
        run_instr(16'hE000, 0, 0, 1'b0);
        run_instr(16'h3456, 1, 0, 1'b0);
        run_instr(16'hF000, 0, 0, 1'b0);
        play(1000);

        // Reset during a pending load
        do_reset();
        run_instr(16'hA000, 1, 10, 1'b0);
        play(6);
        check_eq("memrd_pre_rst", 64'(mem_rd), 64'd1);
        do_reset();
        run_instr(16'h0000, 1, 0, 1'b0);
        play(1000);

        // Randomized programs
        for (int p = 0; p < 40; p++) begin
            do_reset();
            for (int i = 0; i < 12; i++) begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h1;
                r  = $urandom_range(0, 29);
                wf = (r == 0) ? T : (r == 1) ? T - 1 : $urandom_range(0, 3);
                r  = $urandom_range(0, 29);
                wm = (r == 0) ? T : (r == 1) ? T - 1 : $urandom_range(0, 5);
                run_instr({op, 12'($urandom)}, wf, wm, rb());
            end
            play(100000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/scrisc_ctrl_fsm.md
SCRISC_CTRL_FSM -- requirements
Module: scrisc_ctrl_fsm

Interface
REQ-001 Parameter: ACK_TIMEOUT, 15, max wait cycles for imem_ack/mem_ack (1..255).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 instr  in  16  instruction word from instruction memory; valid when imem_ack=1.
REQ-005 imem_ack  in  1  instruction memory ready/acknowledge.
REQ-006 mem_ack  in  1  data memory acknowledge for LD/ST.
REQ-007 check  in  1  branch-condition result from the 16-bit ALU.
REQ-008 imem_req  out  1  instruction fetch request.
REQ-009 ir  out  16  registered instruction.
REQ-010 ir_load / pc_inc / pc_load  out  1 each  datapath strobes.
REQ-011 alu_c  out  4  ALU operation code; alu_b out 3 branch-condition code.
REQ-012 mem_rd / mem_wr  out  1 each  data memory requests.
REQ-013 rf_we  out  1  register-file write enable.
REQ-014 halted, illegal, bus_err  out  1 each  status flags.

Function
REQ-015 All outputs are registered (Moore); states: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-016 IDLE -> FETCH unconditionally on the first edge after reset release.
REQ-017 FETCH: imem_req=1 until imem_ack=1; on the ack cycle ir<=instr, and ir_load=1 and pc_inc=1 pulse for exactly one cycle in the following cycle; the state moves to DECODE.
REQ-018 DECODE (1 cycle) opcode=ir[15:12] sets alu_c: 1 ADD=1100, 2 SUB=1101, 3 AND=1000, 4 OR=1001, 5 XOR=1010, 6 NOR=1011, 7 SLL=0100, 8 SRL=0110, 9 SRA=0111, A LD=1100, B ST=1100, C BR=1101, other=0000.
REQ-019 alu_b=ir[11:9] for BR and 000 otherwise; alu_c and alu_b hold from DECODE until the next DECODE.
REQ-020 Opcodes 1-9: DECODE -> EXEC -> WB (rf_we=1 for one cycle) -> FETCH.
REQ-021 LD: EXEC -> MEM (mem_rd=1 until mem_ack) -> WB -> FETCH.
REQ-022 ST: EXEC -> MEM (mem_wr=1 until mem_ack) -> FETCH; rf_we is never asserted.
REQ-023 BR: in EXEC, pc_load=1 for one cycle if check=1; the state moves to FETCH in either case.
REQ-024 JMP (D): in EXEC, pc_load=1 unconditionally, then FETCH.
REQ-025 NOP (0): DECODE -> FETCH.
REQ-026 HLT (F): DECODE -> HALT; halted=1; HALT is left only by reset.
REQ-027 Opcode E is illegal: illegal is set (sticky until reset) and the instruction executes as NOP.
REQ-028 A wait counter (8 bit) clears on entering FETCH or MEM and increments each cycle without an ack.
REQ-029 When the counter reaches ACK_TIMEOUT without an ack, bus_err is set (sticky), all requests drop, and the state moves to HALT with halted=1.
REQ-030 An ack arriving in the same cycle the counter reaches ACK_TIMEOUT wins: normal progress, no bus_err.
REQ-031 mem_rd and mem_wr are never both 1; imem_req and mem_rd/mem_wr are never both 1.
REQ-032 rf_we, pc_load, pc_inc and ir_load are single-cycle pulses, at most one each per instruction.
REQ-033 Acks received outside FETCH or MEM are ignored.

Reset
REQ-034 rst=1 forces state IDLE immediately, from any state and mid-handshake included.
REQ-035 While rst=1, all outputs are 0, including ir, alu_c, alu_b, halted, illegal and bus_err, and the wait counter is 0.

Verification
REQ-036 ADD: instr=0x1234, imem_ack=1 for one cycle -> ir_load/pc_inc pulse, alu_c=1100, rf_we pulse 3 cycles after the ack, then imem_req=1.
REQ-037 BR: instr=0xC600, check=1 -> alu_b=011, alu_c=1101, pc_load pulses once; repeat with check=0 -> no pc_load, back to FETCH.
REQ-038 LD with mem_ack delayed 4 cycles -> mem_rd held 5 cycles, then rf_we pulse; ST 0xB000 -> mem_wr only, no rf_we.
REQ-039 imem_ack held 0 -> bus_err=1 and halted=1 after ACK_TIMEOUT (15) cycles; a variant with the ack on cycle 15 -> no bus_err.
REQ-040 instr=0xE000 -> illegal=1, no rf_we, no mem access; then HLT 0xF000 -> halted=1; later acks are ignored.
REQ-041 rst asserted mid-MEM with mem_rd=1 -> all outputs 0 asynchronously; after release, IDLE then FETCH with imem_req=1.
